// File: rtl/servo_pkg.sv
// Shared types and constants for the servo slew controller.
package servo_pkg;

  localparam int ANGLE_W = 8;
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = 8'd180;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    DONE = 2'd2
  } state_e;

  // Saturate a raw command to the mechanical range of the servo.
  function automatic logic [ANGLE_W-1:0] sat_angle(input logic [ANGLE_W-1:0] a);
    if (a > ANGLE_MAX) begin
      return ANGLE_MAX;
    end else begin
      return a;
    end
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running slew-update tick: a registered one-cycle pulse every PERIOD
// cycles, realigned by clr so the first pulse lands PERIOD cycles after clr.
module servo_tick_gen #(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and early tick decode (tick registered one cycle ahead of wrap).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Rate-limited servo angle controller: accepts a target angle and slews toward
// it by at most STEP_DEG per update period. Define SERVO_SOFT_LIMIT_EN to clamp
// targets to [MIN_ANGLE, MAX_ANGLE]; otherwise targets only saturate at 180.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned STEP_PERIOD_US = 20_000,
  parameter int unsigned STEP_DEG       = 2,
  parameter int unsigned INIT_ANGLE     = 90,
  parameter int unsigned MIN_ANGLE      = 0,
  parameter int unsigned MAX_ANGLE      = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ANGLE_W-1:0] cmd_angle,
  input  logic               abort,
  output logic [ANGLE_W-1:0] angle,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TICK_N = CLK_FREQ / 1_000_000 * STEP_PERIOD_US;
  localparam logic [ANGLE_W-1:0] STEP_A = ANGLE_W'(STEP_DEG);
  localparam logic [ANGLE_W:0]   STEP_M = (ANGLE_W + 1)'(STEP_DEG);
  localparam logic [ANGLE_W-1:0] INIT_A = ANGLE_W'(INIT_ANGLE);

  state_e              state_q, state_d;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic [ANGLE_W-1:0]  target_q, target_d;
  logic                cmd_ready_q, busy_q, done_q;
  logic                tick_clr;
  logic                tick;
  logic signed [ANGLE_W:0] diff;
  logic [ANGLE_W:0]    mag;

  function automatic logic [ANGLE_W-1:0] limit_target(input logic [ANGLE_W-1:0] a);
`ifdef SERVO_SOFT_LIMIT_EN
    if (a < ANGLE_W'(MIN_ANGLE)) begin
      return ANGLE_W'(MIN_ANGLE);
    end else if (a > ANGLE_W'(MAX_ANGLE)) begin
      return ANGLE_W'(MAX_ANGLE);
    end else begin
      return a;
    end
`else
    return sat_angle(a);
`endif
  endfunction

  servo_tick_gen #(
    .PERIOD (TICK_N)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Signed distance to target; both operands are at most 180, so 9 bits never overflow.
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    if (diff[ANGLE_W]) begin
      mag = $unsigned(-diff);
    end else begin
      mag = $unsigned(diff);
    end
  end

  // Next-state, target capture and slew step.
  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    target_d = target_q;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          target_d = limit_target(cmd_angle);
          tick_clr = 1'b1;
          state_d  = SLEW;
        end else begin
          state_d = IDLE;
        end
      end
      SLEW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (target_q == angle_q) begin
          state_d = DONE;
        end else if (tick) begin
          // Last step may be partial so the angle lands exactly on target.
          if (mag <= STEP_M) begin
            angle_d = target_q;
            state_d = DONE;
          end else if (diff[ANGLE_W]) begin
            angle_d = angle_q - STEP_A;
          end else begin
            angle_d = angle_q + STEP_A;
          end
        end else begin
          state_d = SLEW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      angle_q     <= INIT_A;
      target_q    <= INIT_A;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d == SLEW);
      done_q      <= (state_d == DONE);
    end
  end

  assign angle     = angle_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with a 10-cycle update period.
module tb_servo_slew_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_angle = 8'd0;
  logic       abort = 1'b0;
  logic [7:0] angle;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  servo_slew_ctrl #(
    .CLK_FREQ       (1_000_000),
    .STEP_PERIOD_US (10),
    .STEP_DEG       (2),
    .INIT_ANGLE     (90),
    .MIN_ANGLE      (0),
    .MAX_ANGLE      (150)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_angle (cmd_angle),
    .abort     (abort),
    .angle     (angle),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #1;
    step(3);
    rst_n = 1'b1;
  endtask

  // Present one command; returns just after the accepting edge.
  task automatic send(input logic [7:0] a);
    cmd_valid = 1'b1;
    cmd_angle = a;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int final_a;
    int cyc;
`ifdef SERVO_SOFT_LIMIT_EN
    final_a = 150;
`else
    final_a = 180;
`endif

    // Reset values
    do_reset();
    check_vec("rst_angle_held", {24'd0, angle}, 90);
    step(1);
    check_vec("rst_angle", {24'd0, angle}, 90);
    check_vec("rst_ready", {31'd0, cmd_ready}, 1);
    check_vec("rst_busy", {31'd0, busy}, 0);
    check_vec("rst_done", {31'd0, done}, 0);

    // 90 -> 96, with a command offered mid-slew that must be dropped
    send(8'd96);
    check_vec("up_busy", {31'd0, busy}, 1);
    check_vec("up_ready", {31'd0, cmd_ready}, 0);
    step(4);
    cmd_valid = 1'b1;
    cmd_angle = 8'd10;
    step(1);
    cmd_valid = 1'b0;
    step(4);
    check_vec("up_pre_tick", {24'd0, angle}, 90);
    step(1);
    check_vec("up_t1", {24'd0, angle}, 92);
    step(10);
    check_vec("up_t2", {24'd0, angle}, 94);
    check_vec("up_t2_done", {31'd0, done}, 0);
    step(10);
    check_vec("up_t3", {24'd0, angle}, 96);
    check_vec("up_done", {31'd0, done}, 1);
    check_vec("up_done_busy", {31'd0, busy}, 0);
    step(1);
    check_vec("up_done_clr", {31'd0, done}, 0);
    check_vec("up_idle_ready", {31'd0, cmd_ready}, 1);
    step(15);
    check_vec("up_no_queue", {24'd0, angle}, 96);
    check_vec("up_idle_busy", {31'd0, busy}, 0);

    // 90 -> 85 with a final partial step
    do_reset();
    step(1);
    send(8'd85);
    step(10);
    check_vec("dn_t1", {24'd0, angle}, 88);
    step(10);
    check_vec("dn_t2", {24'd0, angle}, 86);
    step(10);
    check_vec("dn_t3", {24'd0, angle}, 85);
    check_vec("dn_done", {31'd0, done}, 1);
    step(20);
    check_vec("dn_hold", {24'd0, angle}, 85);

    // Target equal to current angle
    do_reset();
    step(1);
    send(8'd90);
    step(1);
    check_vec("eq_done", {31'd0, done}, 1);
    check_vec("eq_angle", {24'd0, angle}, 90);
    step(1);
    check_vec("eq_ready", {31'd0, cmd_ready}, 1);

    // Abort coinciding with the 3rd tick
    do_reset();
    step(1);
    send(8'd0);
    step(10);
    check_vec("ab_t1", {24'd0, angle}, 88);
    step(10);
    check_vec("ab_t2", {24'd0, angle}, 86);
    step(9);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_vec("ab_angle", {24'd0, angle}, 86);
    check_vec("ab_no_done", {31'd0, done}, 0);
    check_vec("ab_busy", {31'd0, busy}, 0);
    check_vec("ab_ready", {31'd0, cmd_ready}, 1);
    step(1);
    check_vec("ab_no_done2", {31'd0, done}, 0);
    step(20);
    check_vec("ab_hold", {24'd0, angle}, 86);

    // Abort while idle must not block acceptance
    abort = 1'b1;
    send(8'd88);
    abort = 1'b0;
    check_vec("abi_busy", {31'd0, busy}, 1);
    step(10);
    check_vec("abi_angle", {24'd0, angle}, 88);
    check_vec("abi_done", {31'd0, done}, 1);

    // Out-of-range command, then reset mid-slew
    do_reset();
    step(1);
    send(8'd200);
    cyc = 0;
    while (!done && cyc < 1000) begin
      step(1);
      cyc++;
    end
    check_vec("lim_done", {31'd0, done}, 1);
    check_vec("lim_angle", {24'd0, angle}, final_a);
    step(1);
    send(8'd0);
    step(25);
    check_vec("mid_angle", {24'd0, angle}, final_a - 4);
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_angle", {24'd0, angle}, 90);
    check_vec("mid_rst_busy", {31'd0, busy}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check_vec("mid_rel_ready", {31'd0, cmd_ready}, 1);
    step(30);
    check_vec("mid_discard", {24'd0, angle}, 90);
    check_vec("mid_discard_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
